axicb_fifo_rr_sched: RTL and testbench

//  Round-robin scheduler draining N single-clock FIFOs (pull/empty read side) into one

---
 rtl/axicb_fifo_rr_sched.sv | 156 +++++++++++++++
 tb/tb_axicb_fifo_rr_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axicb_fifo_rr_sched.sv
// Round-robin scheduler that drains NB_REQ pull-style FIFOs into one
// registered valid/ready stream. A grant is held until a packet's last
// beat, or until MAX_BEATS beats have gone out (0 = no beat limit).
module axicb_fifo_rr_sched #(
  parameter int unsigned NB_REQ     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         srst,
  input  logic [NB_REQ-1:0]            req_empty,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NB_REQ-1:0]            req_last,
  output logic [NB_REQ-1:0]            req_pull,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(NB_REQ)-1:0]    m_id,
  output logic                         m_last,
  output logic                         busy
);

  localparam int unsigned IW = $clog2(NB_REQ);
  // With MAX_BEATS=0 the counter is never advanced; keep one bit so it still exists.
  localparam int unsigned CW = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [IW-1:0]         m_id_q, m_id_d;
  logic                  m_last_q, m_last_d;

  logic [DATA_WIDTH-1:0] data_arr [NB_REQ];
  logic                  out_free;
  logic                  pull_en;
  logic                  last_beat;
  logic                  found;
  logic [IW-1:0]         pick;

  // Unpack the flat FIFO data bus into per-requester slices.
  always_comb begin
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first non-empty FIFO at or after rr_q, wrapping.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      idx = (int'(rr_q) + k) % NB_REQ;
      if (!found && !req_empty[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Pull strobe for the granted FIFO; srst suppresses it so FIFOs stay untouched.
  always_comb begin
    out_free  = !m_valid_q || m_ready;
    pull_en   = !srst && (state_q == GRANT) && out_free && !req_empty[grant_q];
    last_beat = req_last[grant_q] || ((MAX_BEATS != 0) && (cnt_q == CNT_LAST));
    req_pull  = '0;
    if (pull_en) begin
      req_pull[grant_q] = 1'b1;
    end
  end

  // Next-state logic for the FSM, arbitration state and output register.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;

    if (state_q == IDLE) begin
      if (found) begin
        grant_d = pick;
        state_d = GRANT;
      end
    end

    if (pull_en) begin
      m_valid_d = 1'b1;
      m_data_d  = data_arr[grant_q];
      m_id_d    = grant_q;
      m_last_d  = last_beat;
      if (last_beat) begin
        rr_d    = (grant_q == IW'(NB_REQ - 1)) ? '0 : grant_q + 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else if (MAX_BEATS != 0) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (srst) begin
      state_d   = IDLE;
      grant_d   = '0;
      rr_d      = '0;
      cnt_d     = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_id_d    = '0;
      m_last_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_id    = m_id_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_axicb_fifo_rr_sched.sv
// Bench for axicb_fifo_rr_sched: FIFOs are modelled as queues, and a
// transaction-level reference model predicts pulls and output beats.
module tb_axicb_fifo_rr_sched;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              srst;
  logic [NB-1:0]     req_empty;
  logic [NB*DW-1:0]  req_data;
  logic [NB-1:0]     req_last;
  logic [NB-1:0]     req_pull;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_id;
  logic              m_last;
  logic              busy;

  axicb_fifo_rr_sched #(
    .NB_REQ    (NB),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .req_empty(req_empty),
    .req_data (req_data),
    .req_last (req_last),
    .req_pull (req_pull),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_id     (m_id),
    .m_last   (m_last),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { int id; logic [7:0] d; logic l; } obs_t;

  beat_t fq [NB][$];
  obs_t  acc[$];
  obs_t  ex[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: which FIFO owns the channel, where the next search
  // starts, beats sent in this grant, and the contents of the output register.
  bit         m_owned;
  int         m_owner;
  int         m_next;
  int         m_sent;
  logic       e_valid;
  logic [7:0] e_data;
  int         e_id;
  logic       e_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owned = 0; m_owner = 0; m_next = 0; m_sent = 0;
    e_valid = 0; e_data = '0; e_id = 0; e_last = 0;
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < NB; i++) begin
      req_empty[i] = (fq[i].size() == 0);
      if (fq[i].size() != 0) begin
        req_data[i*DW +: DW] = fq[i][0].d;
        req_last[i]          = fq[i][0].l;
      end else begin
        req_data[i*DW +: DW] = DW'($urandom);
        req_last[i]          = 1'($urandom);
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    fq[i].push_back(b);
  endtask

  task automatic expect_beat(input int id, input logic [7:0] d, input logic l);
    obs_t o;
    o.id = id; o.d = d; o.l = l;
    ex.push_back(o);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, acc.size(), ex.size());
    for (int k = 0; k < ex.size() && k < acc.size(); k++) begin
      chk({tag, "_id"},   acc[k].id, ex[k].id);
      chk({tag, "_data"}, acc[k].d,  ex[k].d);
      chk({tag, "_last"}, acc[k].l,  ex[k].l);
    end
    acc.delete();
    ex.delete();
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic cycle(input bit rdy, input bit sr);
    logic [NB-1:0] exp_pull;
    beat_t         b;
    bit            close;
    m_ready = rdy;
    srst    = sr;
    drive_fifos();
    #1;
    exp_pull = '0;
    if (!sr && m_owned && (!e_valid || rdy) && fq[m_owner].size() != 0)
      exp_pull[m_owner] = 1'b1;
    chk("req_pull", req_pull, exp_pull);
    if (m_valid === 1'b1 && rdy) begin
      obs_t o;
      o.id = int'(m_id); o.d = m_data; o.l = m_last;
      acc.push_back(o);
    end
    if (sr) begin
      model_reset();
    end else if (!m_owned) begin
      if (rdy) e_valid = 0;
      for (int k = 0; k < NB; k++) begin
        if (!m_owned && fq[(m_next + k) % NB].size() != 0) begin
          m_owned = 1;
          m_owner = (m_next + k) % NB;
        end
      end
    end else if (exp_pull != '0) begin
      b = fq[m_owner].pop_front();
      close   = b.l || (m_sent == MB - 1);
      e_valid = 1; e_data = b.d; e_id = m_owner; e_last = close;
      if (close) begin
        m_next  = (m_owner + 1) % NB;
        m_sent  = 0;
        m_owned = 0;
      end else begin
        m_sent++;
      end
    end else if (rdy) begin
      e_valid = 0;
    end
    @(negedge aclk);
    chk("m_valid", m_valid, e_valid);
    chk("m_data",  m_data,  e_data);
    chk("m_id",    m_id,    e_id);
    chk("m_last",  m_last,  e_last);
    chk("busy",    busy,    m_owned);
  endtask

  initial begin
    aresetn = 1'b0;
    srst    = 1'b0;
    m_ready = 1'b0;
    drive_fifos();
    model_reset();
    @(negedge aclk);
    chk("rst_m_valid",  m_valid,  0);
    chk("rst_m_data",   m_data,   0);
    chk("rst_m_id",     m_id,     0);
    chk("rst_m_last",   m_last,   0);
    chk("rst_busy",     busy,     0);
    chk("rst_req_pull", req_pull, 0);
    aresetn = 1'b1;

    // Single three-beat packet from FIFO0 with the sink always ready.
    push(0, 8'h10, 0); push(0, 8'h11, 0); push(0, 8'h12, 1);
    repeat (8) cycle(1, 0);
    expect_beat(0, 8'h10, 0); expect_beat(0, 8'h11, 0); expect_beat(0, 8'h12, 1);
    check_log("t1");

    // One last-beat per FIFO, two rounds, search restarting from index 0.
    cycle(1, 1);
    acc.delete();
    for (int i = 0; i < NB; i++) push(i, 8'hA0 + 8'(i), 1);
    repeat (12) cycle(1, 0);
    for (int i = 0; i < NB; i++) push(i, 8'hB0 + 8'(i), 1);
    repeat (12) cycle(1, 0);
    for (int i = 0; i < NB; i++) expect_beat(i, 8'hA0 + 8'(i), 1);
    for (int i = 0; i < NB; i++) expect_beat(i, 8'hB0 + 8'(i), 1);
    check_log("t2");

    // Backpressure on FIFO2's first beat: output held, no second pull.
    push(2, 8'h21, 0); push(2, 8'h22, 1);
    cycle(1, 0); cycle(1, 0);
    repeat (3) cycle(0, 0);
    repeat (5) cycle(1, 0);
    expect_beat(2, 8'h21, 0); expect_beat(2, 8'h22, 1);
    check_log("t3");

    // Beat budget: FIFO1 streams without last, FIFO3 gets a turn every 4 beats.
    cycle(1, 1);
    acc.delete();
    for (int k = 0; k < 10; k++) push(1, 8'h40 + 8'(k), 0);
    push(3, 8'h70, 1);
    repeat (20) cycle(1, 0);
    push(1, 8'h4A, 1);
    repeat (6) cycle(1, 0);
    for (int k = 0; k < 4; k++) expect_beat(1, 8'h40 + 8'(k), k == 3);
    expect_beat(3, 8'h70, 1);
    for (int k = 4; k < 8; k++) expect_beat(1, 8'h40 + 8'(k), k == 7);
    expect_beat(1, 8'h48, 0); expect_beat(1, 8'h49, 0); expect_beat(1, 8'h4A, 1);
    check_log("t4");

    // Packet lock: FIFO0 runs dry mid-packet, FIFO1 must wait.
    cycle(1, 1);
    acc.delete();
    push(0, 8'h50, 0); push(0, 8'h51, 0); push(1, 8'h60, 1);
    repeat (8) cycle(1, 0);
    push(0, 8'h52, 1);
    repeat (8) cycle(1, 0);
    expect_beat(0, 8'h50, 0); expect_beat(0, 8'h51, 0); expect_beat(0, 8'h52, 1);
    expect_beat(1, 8'h60, 1);
    check_log("t5");

    // Synchronous reset while a stalled beat sits in the output register.
    push(0, 8'h80, 0); push(0, 8'h81, 0); push(0, 8'h82, 1);
    cycle(0, 0); cycle(1, 0);
    repeat (2) cycle(0, 0);
    cycle(0, 1);
    chk("srst_m_valid",  m_valid,  0);
    chk("srst_busy",     busy,     0);
    #1;
    chk("srst_req_pull", req_pull, 0);
    repeat (8) cycle(1, 0);
    expect_beat(0, 8'h81, 0); expect_beat(0, 8'h82, 1);
    check_log("t6");

    // Randomized traffic, backpressure and occasional synchronous resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (fq[i].size() < 6 && $urandom_range(99) < 30)
          push(i, 8'($urandom), ($urandom_range(3) == 0));
      end
      cycle($urandom_range(3) != 0, $urandom_range(299) == 0);
    end
    for (int i = 0; i < NB; i++) push(i, 8'hEE, 1);
    repeat (60) cycle(1, 0);
    chk("drained_valid", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
